// File: rtl/scaled_dot_product_pipe.sv
// Attention-score engine: one held Q vector against a stream of K/V rows,
// producing sat(round((Q.K) >>> shift)) with the matching V row, elastic end to end.
module scaled_dot_product_pipe #(
    parameter int DIM     = 64,
    parameter int ELEM_W  = 8,
    parameter int SCORE_W = 8,
    parameter int LEN_W   = 10,
    parameter int SHIFT_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LEN_W-1:0]          cfg_kv_len,
    input  logic [SHIFT_W-1:0]        cfg_shift,
    input  logic                      q_vld,
    output logic                      q_rdy,
    input  logic [DIM*ELEM_W-1:0]     q_data,
    input  logic                      kv_vld,
    output logic                      kv_rdy,
    input  logic [DIM*ELEM_W-1:0]     k_data,
    input  logic [DIM*ELEM_W-1:0]     v_data,
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic signed [SCORE_W-1:0] s_out,
    output logic [DIM*ELEM_W-1:0]     v_out,
    output logic                      out_last
);
    localparam int LVLS  = $clog2(DIM);
    localparam int SUM_W = 2*ELEM_W + LVLS;
    localparam int VW    = DIM*ELEM_W;
    localparam logic [LEN_W-1:0]   ONE_LEN = LEN_W'(1);
    localparam logic [SHIFT_W-1:0] ONE_SH  = SHIFT_W'(1);

    typedef enum logic [0:0] {ST_EMPTY = 1'b0, ST_HOLD = 1'b1} q_state_t;

    q_state_t             state_r, state_s;
    logic [VW-1:0]        q_r;
    logic [LEN_W-1:0]     rows_left_r;
    logic [SHIFT_W-1:0]   shift_r;
    logic                 q_acc_s, kv_acc_s, last_row_s, adv_so_s;
    logic [LVLS:0]        vld_r, last_r, adv_s;
    logic [VW-1:0]        v_r  [LVLS+1];
    logic [SHIFT_W-1:0]   sh_r [LVLS+1];

    // Round half toward +inf in SUM_W+1 bits, then clamp to the score range.
    function automatic logic signed [SCORE_W-1:0] scale_sat(
        input logic signed [SUM_W-1:0] sum,
        input logic [SHIFT_W-1:0]      sh
    );
        logic signed [SUM_W:0] ext, rnd, t, one_c;
        one_c = (SUM_W+1)'(1);
        ext   = {sum[SUM_W-1], sum};
        if (sh == '0) begin
            rnd = ext;
        end else begin
            rnd = ext + (one_c <<< (sh - ONE_SH));
        end
        t = rnd >>> sh;
        if ((&t[SUM_W:SCORE_W-1]) || !(|t[SUM_W:SCORE_W-1])) begin
            scale_sat = t[SCORE_W-1:0];
        end else if (t[SUM_W]) begin
            scale_sat = {1'b1, {(SCORE_W-1){1'b0}}};
        end else begin
            scale_sat = {1'b0, {(SCORE_W-1){1'b1}}};
        end
    endfunction

    // A stage may load when it, or any stage after it, has room.
    assign adv_so_s = !out_vld || out_rdy;
    for (genvar n = 0; n <= LVLS; n++) begin : g_adv
        assign adv_s[n] = adv_so_s || !(&vld_r[LVLS:n]);
    end

    // Handshakes and Q-hold next state.
    always_comb begin
        kv_rdy     = (state_r == ST_HOLD) && adv_s[0];
        kv_acc_s   = kv_vld && kv_rdy;
        last_row_s = (rows_left_r == ONE_LEN);
        q_rdy      = (state_r == ST_EMPTY) || (kv_acc_s && last_row_s);
        q_acc_s    = q_vld && q_rdy;
        state_s    = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (q_acc_s) state_s = ST_HOLD;
                else         state_s = ST_EMPTY;
            end
            ST_HOLD: begin
                if (kv_acc_s && last_row_s && !q_acc_s) state_s = ST_EMPTY;
                else                                    state_s = ST_HOLD;
            end
            default: state_s = ST_EMPTY;
        endcase
    end

    // Q-hold state, latched Q vector, row budget and scale.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            q_r         <= '0;
            rows_left_r <= '0;
            shift_r     <= '0;
        end else begin
            state_r <= state_s;
            if (q_acc_s) begin
                q_r         <= q_data;
                rows_left_r <= (cfg_kv_len == '0) ? ONE_LEN : cfg_kv_len;
                shift_r     <= cfg_shift;
            end else if (kv_acc_s) begin
                rows_left_r <= rows_left_r - ONE_LEN;
            end
        end
    end

    // Stage valids and last tags; bubbles carry last=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_r  <= '0;
            last_r <= '0;
        end else begin
            if (adv_s[0]) begin
                vld_r[0]  <= kv_acc_s;
                last_r[0] <= kv_acc_s && last_row_s;
            end
            for (int n = 1; n <= LVLS; n++) begin
                if (adv_s[n]) begin
                    vld_r[n]  <= vld_r[n-1];
                    last_r[n] <= last_r[n-1];
                end
            end
        end
    end

    // V row and per-row shift travel alongside the partial sums.
    always_ff @(posedge clk) begin
        if (adv_s[0]) begin
            v_r[0]  <= v_data;
            sh_r[0] <= shift_r;
        end
        for (int n = 1; n <= LVLS; n++) begin
            if (adv_s[n]) begin
                v_r[n]  <= v_r[n-1];
                sh_r[n] <= sh_r[n-1];
            end
        end
    end

    // Level 0 holds the element products; each later level halves the count.
    for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
        localparam int N = DIM >> l;
        localparam int W = 2*ELEM_W + l;
        logic signed [W-1:0] sum_r [N];
        if (l == 0) begin : g_mul
            // Element-wise signed products.
            always_ff @(posedge clk) begin
                if (adv_s[0]) begin
                    for (int i = 0; i < N; i++) begin
                        sum_r[i] <= $signed(q_r[i*ELEM_W +: ELEM_W]) *
                                    $signed(k_data[i*ELEM_W +: ELEM_W]);
                    end
                end
            end
        end else begin : g_add
            // Pairwise sign-extended adds.
            always_ff @(posedge clk) begin
                if (adv_s[l]) begin
                    for (int i = 0; i < N; i++) begin
                        sum_r[i] <= {g_lvl[l-1].sum_r[2*i][W-2],   g_lvl[l-1].sum_r[2*i]} +
                                    {g_lvl[l-1].sum_r[2*i+1][W-2], g_lvl[l-1].sum_r[2*i+1]};
                    end
                end
            end
        end
    end

    // Output register: scale, saturate, hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_last <= 1'b0;
            s_out    <= '0;
            v_out    <= '0;
        end else if (adv_so_s) begin
            out_vld  <= vld_r[LVLS];
            out_last <= last_r[LVLS];
            s_out    <= scale_sat(g_lvl[LVLS].sum_r[0], sh_r[LVLS]);
            v_out    <= v_r[LVLS];
        end
    end
endmodule

// File: tb/tb_scaled_dot_product_pipe.sv
// Directed bench for scaled_dot_product_pipe: scoring, rounding, saturation,
// back-pressure, Q turnover and mid-stream reset against hand-computed values.
module tb_scaled_dot_product_pipe;
    localparam int DIM = 64, ELEM_W = 8, SCORE_W = 8, LEN_W = 10, SHIFT_W = 4;
    localparam int VW = DIM*ELEM_W;
    localparam int LAT = 8;
    localparam int NSTAGE = 8;

    localparam int NV = 9;
    localparam int TQ [NV] = '{1, 1, 1, 1, 1, 127, -128, 1, 2};
    localparam int TKC[NV] = '{64, 12, 11, 5, 12, 64, 64, 64, 64};
    localparam int TKV[NV] = '{1, 1, 1, 1, -1, 127, 127, 1, 3};
    localparam int TSH[NV] = '{3, 3, 3, 0, 3, 3, 3, 0, 2};
    localparam int TEX[NV] = '{8, 2, 1, 5, -1, 127, -128, 64, 96};

    logic clk = 1'b0;
    logic rst;
    logic [LEN_W-1:0] cfg_kv_len;
    logic [SHIFT_W-1:0] cfg_shift;
    logic q_vld, q_rdy, kv_vld, kv_rdy, out_vld, out_rdy, out_last;
    logic [VW-1:0] q_data, k_data, v_data, v_out;
    logic signed [SCORE_W-1:0] s_out;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int acc_cyc_q[$];
    int out_s_q[$];
    logic [VW-1:0] out_v_q[$];
    logic out_l_q[$];
    int out_cyc_q[$];

    scaled_dot_product_pipe #(.DIM(DIM), .ELEM_W(ELEM_W), .SCORE_W(SCORE_W),
                              .LEN_W(LEN_W), .SHIFT_W(SHIFT_W)) dut (
        .clk(clk), .rst(rst), .cfg_kv_len(cfg_kv_len), .cfg_shift(cfg_shift),
        .q_vld(q_vld), .q_rdy(q_rdy), .q_data(q_data),
        .kv_vld(kv_vld), .kv_rdy(kv_rdy), .k_data(k_data), .v_data(v_data),
        .out_vld(out_vld), .out_rdy(out_rdy), .s_out(s_out), .v_out(v_out),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record accepts and delivered outputs mid-cycle.
    always @(negedge clk) begin
        if (kv_vld && kv_rdy) begin
            acc_cnt <= acc_cnt + 1;
            acc_cyc_q.push_back(cyc);
        end
        if (out_vld && out_rdy) begin
            out_s_q.push_back(int'(s_out));
            out_v_q.push_back(v_out);
            out_l_q.push_back(out_last);
            out_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] fill(input int val, input int cnt);
        logic [VW-1:0] r;
        logic [ELEM_W-1:0] e;
        r = '0;
        e = val[ELEM_W-1:0];
        for (int i = 0; i < DIM; i++) begin
            if (i < cnt) r[i*ELEM_W +: ELEM_W] = e;
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] vpat(input int seed);
        logic [VW-1:0] r;
        int t;
        for (int i = 0; i < DIM; i++) begin
            t = seed*7 + i;
            r[i*ELEM_W +: ELEM_W] = t[ELEM_W-1:0];
        end
        return r;
    endfunction

    task automatic clear_q();
        acc_cyc_q.delete();
        out_s_q.delete();
        out_v_q.delete();
        out_l_q.delete();
        out_cyc_q.delete();
    endtask

    task automatic send_q(input logic [VW-1:0] q, input int len, input int sh);
        q_data     = q;
        cfg_kv_len = len[LEN_W-1:0];
        cfg_shift  = sh[SHIFT_W-1:0];
        q_vld      = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (q_rdy) break;
        end
        check_eq("q_wait", q_rdy, 1);
        @(posedge clk);
        #1;
        q_vld = 1'b0;
    endtask

    // Leaves kv_vld high so consecutive calls stream one row per cycle.
    task automatic send_kv(input logic [VW-1:0] k, input logic [VW-1:0] v, output logic qr);
        k_data = k;
        v_data = v;
        kv_vld = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (kv_rdy) break;
        end
        qr = q_rdy;
        check_eq("kv_wait", kv_rdy, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_outs(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && out_s_q.size() < n; i++) @(posedge clk);
        #1;
        check_eq(tag, out_s_q.size(), n);
    endtask

    initial begin
        logic qr, qr1, qr2;
        int base;
        int exp_s[4];
        rst = 1'b1; q_vld = 1'b0; kv_vld = 1'b0; out_rdy = 1'b0;
        cfg_kv_len = '0; cfg_shift = '0; q_data = '0; k_data = '0; v_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_q_rdy", q_rdy, 1);
        check_eq("rst_kv_rdy", kv_rdy, 0);
        check_eq("rst_out_vld", out_vld, 0);
        check_eq("rst_out_last", out_last, 0);
        check_eq("rst_s_out", s_out, 0);
        check_eq("rst_v_out", v_out, 0);
        rst = 1'b0;
        out_rdy = 1'b1;
        @(posedge clk);
        #1;

        // Single-row vectors: nominal, rounding both signs, shift 0, saturation.
        for (int t = 0; t < NV; t++) begin
            clear_q();
            send_q(fill(TQ[t], DIM), 1, TSH[t]);
            send_kv(fill(TKV[t], TKC[t]), vpat(t), qr);
            kv_vld = 1'b0;
            wait_outs($sformatf("vec%0d_cnt", t), 1, 30);
            if (out_s_q.size() > 0 && acc_cyc_q.size() > 0) begin
                check_eq($sformatf("vec%0d_s", t), out_s_q[0], TEX[t]);
                check_eq($sformatf("vec%0d_v", t), out_v_q[0], vpat(t));
                check_eq($sformatf("vec%0d_last", t), out_l_q[0], 1);
                check_eq($sformatf("vec%0d_lat", t), out_cyc_q[0] - acc_cyc_q[0], LAT);
            end
        end

        // Back-pressure: 20 rows, output stalled 30 cycles; row j scores j.
        clear_q();
        out_rdy = 1'b0;
        send_q(fill(1, DIM), 20, 0);
        base = acc_cnt;
        fork
            begin
                logic qrb;
                for (int j = 1; j <= 20; j++) send_kv(fill(1, j), fill(j, 1), qrb);
                kv_vld = 1'b0;
            end
            begin
                repeat (30) @(posedge clk);
                #1;
                check_eq("bp_kv_rdy", kv_rdy, 0);
                check_eq("bp_fill", acc_cnt - base, NSTAGE);
                check_eq("bp_out_vld", out_vld, 1);
                check_eq("bp_s_hold", int'(s_out), 1);
                out_rdy = 1'b1;
            end
        join
        wait_outs("bp_cnt", 20, 100);
        for (int j = 0; j < out_s_q.size() && j < 20; j++) begin
            check_eq($sformatf("bp%0d_s", j + 1), out_s_q[j], j + 1);
            check_eq($sformatf("bp%0d_v", j + 1), out_v_q[j], fill(j + 1, 1));
            check_eq($sformatf("bp%0d_last", j + 1), out_l_q[j], (j == 19) ? 1 : 0);
        end

        // Q turnover: second Q offered while the first is still streaming.
        clear_q();
        send_q(fill(1, DIM), 2, 3);
        q_data = fill(1, DIM); cfg_kv_len = 10'd2; cfg_shift = 4'd1; q_vld = 1'b1;
        send_kv(fill(1, 20), fill(1, 1), qr1);
        send_kv(fill(1, 13), fill(2, 1), qr2);
        q_vld = 1'b0;
        send_kv(fill(1, 7), fill(3, 1), qr);
        send_kv(fill(1, 30), fill(4, 1), qr);
        kv_vld = 1'b0;
        check_eq("to_q_rdy_row1", qr1, 0);
        check_eq("to_q_rdy_row2", qr2, 1);
        wait_outs("to_cnt", 4, 40);
        exp_s = '{3, 2, 4, 15};
        if (out_s_q.size() >= 4 && acc_cyc_q.size() >= 4) begin
            for (int j = 0; j < 4; j++) begin
                check_eq($sformatf("to%0d_s", j + 1), out_s_q[j], exp_s[j]);
                check_eq($sformatf("to%0d_last", j + 1), out_l_q[j], j[0]);
                check_eq($sformatf("to%0d_v", j + 1), out_v_q[j], fill(j + 1, 1));
            end
            check_eq("to_acc_gap", acc_cyc_q[3] - acc_cyc_q[0], 3);
            check_eq("to_out_gap", out_cyc_q[3] - out_cyc_q[0], 3);
        end

        // Reset with five rows in flight, then a fresh Q/KV.
        clear_q();
        send_q(fill(1, DIM), 10, 0);
        for (int r = 1; r <= 5; r++) send_kv(fill(1, 40 + r), fill(40 + r, 1), qr);
        kv_vld = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("mr_out_vld", out_vld, 0);
        check_eq("mr_q_rdy", q_rdy, 1);
        check_eq("mr_kv_rdy", kv_rdy, 0);
        check_eq("mr_pre_outs", out_s_q.size(), 0);
        clear_q();
        send_q(fill(1, DIM), 1, 0);
        send_kv(fill(1, 9), fill(9, 1), qr);
        kv_vld = 1'b0;
        wait_outs("mr_first", 1, 30);
        repeat (15) @(posedge clk);
        #1;
        check_eq("mr_total", out_s_q.size(), 1);
        if (out_s_q.size() > 0) begin
            check_eq("mr_s", out_s_q[0], 9);
            check_eq("mr_v", out_v_q[0], fill(9, 1));
            check_eq("mr_last", out_l_q[0], 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
